// File: rtl/rr_grant_arbiter_16.sv
// Round-robin arbiter sharing one resource among 16 requesters.
// A 4-bit winner index is registered and the one-hot grant word is driven
// from it. A grant is held until the winner drops its request, enable falls,
// or the MAX_HOLD limit expires. The priority pointer then moves past the winner.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   enable       arbitration enable; low blocks new grants and aborts a held one
//   req[15:0]    request vector, bit k = requester k
//   grant[15:0]  registered one-hot grant, zero when idle
//   grant_id     registered binary index of the current/last winner
//   grant_valid  high while a grant is held (== |grant)
//   timeout      one-cycle pulse when a grant is revoked by MAX_HOLD
module rr_grant_arbiter_16 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  grant_id,
    output logic        grant_valid,
    output logic        timeout
);

    localparam int unsigned N   = 16;
    localparam int unsigned IDW = 4;
    // Counter ceiling: MAX_HOLD, or all-ones when the hold time is unlimited.
    localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q, timeout_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             win_found_c;
    logic [IDW-1:0]   win_id_c;
    logic [IDW-1:0]   scan_idx_c;
    logic             hold_limit_c;

    // Winner search: first set request scanning ptr, ptr+1, ... modulo 16.
    always_comb begin
        win_found_c = 1'b0;
        win_id_c    = ptr_q;
        scan_idx_c  = ptr_q;
        for (int i = 0; i < N; i++) begin
            scan_idx_c = ptr_q + IDW'(i);
            if (!win_found_c && req[scan_idx_c]) begin
                win_found_c = 1'b1;
                win_id_c    = scan_idx_c;
            end
        end
    end

    assign hold_limit_c = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_SAT);

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable && win_found_c) begin
                    state_d             = S_GRANT;
                    grant_id_d          = win_id_c;
                    grant_d             = '0;
                    grant_d[win_id_c]   = 1'b1;
                    grant_valid_d       = 1'b1;
                    hold_cnt_d          = CNT_W'(1);
                end
            end
            S_GRANT: begin
                // Release priority: abort, request dropped, hold limit.
                if (!enable || !req[grant_id_q] || hold_limit_c) begin
                    state_d       = S_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_id_q + IDW'(1);
                    hold_cnt_d    = '0;
                    timeout_d     = enable && req[grant_id_q];
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter_16.sv
// Self-checking bench for rr_grant_arbiter_16 (MAX_HOLD = 16).
module tb_rr_grant_arbiter_16;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        grant_valid;
    logic        timeout;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] req;
        logic [15:0] e_grant;
        logic [3:0]  e_id;
        logic        e_valid;
        logic        e_to;
    } vec_t;

    typedef struct {
        logic [15:0] grant;
        logic [3:0]  id;
        logic        valid;
        logic        to;
    } exp_t;

    localparam int NV = 26;
    vec_t tbl[NV];
    exp_t sb_q[$];

    rr_grant_arbiter_16 #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic r, logic e, logic [15:0] q, logic [15:0] g,
                                logic [3:0] id, logic v, logic t);
        vec_t x;
        x.rst_n = r; x.en = e; x.req = q;
        x.e_grant = g; x.e_id = id; x.e_valid = v; x.e_to = t;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, queue its expectation, and compare after the edge.
    task automatic step(vec_t v, string tag);
        exp_t e, got;
        reset_n = v.rst_n;
        enable  = v.en;
        req     = v.req;
        e.grant = v.e_grant; e.id = v.e_id; e.valid = v.e_valid; e.to = v.e_to;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s sb_empty: got empty queue, required entry", tag);
            return;
        end
        n_checks--;
        got = sb_q.pop_front();
        check({tag, " grant"},   32'(grant),       32'(got.grant));
        check({tag, " id"},      32'(grant_id),    32'(got.id));
        check({tag, " valid"},   32'(grant_valid), 32'(got.valid));
        check({tag, " timeout"}, 32'(timeout),     32'(got.to));
        // Structural invariants on every sampled cycle.
        check({tag, " onehot"},  32'((grant & (grant - 16'd1)) == 16'd0), 32'(1));
        check({tag, " valid_or"}, 32'(grant_valid), 32'(|grant));
        if (grant_valid === 1'b1) begin
            logic [15:0] oh;
            oh = 16'd1 << grant_id;
            check({tag, " grant_vs_id"}, 32'(grant), 32'(oh));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        enable   = 1'b0;
        req      = 16'h0000;

        // Reset and basic grant
        tbl[0]  = mk(0, 1, 16'hFFFF, 16'h0000, 4'd0,  0, 0);
        tbl[1]  = mk(0, 1, 16'hFFFF, 16'h0000, 4'd0,  0, 0);
        tbl[2]  = mk(1, 1, 16'h0010, 16'h0010, 4'd4,  1, 0);
        tbl[3]  = mk(1, 1, 16'h0000, 16'h0000, 4'd4,  0, 0);
        // Reset pointer to 0, then round robin on 16'h8001
        tbl[4]  = mk(0, 1, 16'h0000, 16'h0000, 4'd0,  0, 0);
        tbl[5]  = mk(1, 1, 16'h8001, 16'h0001, 4'd0,  1, 0);
        tbl[6]  = mk(1, 1, 16'h8001, 16'h0001, 4'd0,  1, 0);
        tbl[7]  = mk(1, 1, 16'h8001, 16'h0001, 4'd0,  1, 0);
        tbl[8]  = mk(1, 1, 16'h8000, 16'h0000, 4'd0,  0, 0);
        tbl[9]  = mk(1, 1, 16'h8001, 16'h8000, 4'd15, 1, 0);
        tbl[10] = mk(1, 1, 16'hFFFF, 16'h8000, 4'd15, 1, 0);
        tbl[11] = mk(1, 1, 16'h8001, 16'h8000, 4'd15, 1, 0);
        tbl[12] = mk(1, 1, 16'h0001, 16'h0000, 4'd15, 0, 0);
        tbl[13] = mk(1, 1, 16'h8001, 16'h0001, 4'd0,  1, 0);
        tbl[14] = mk(1, 1, 16'h0000, 16'h0000, 4'd0,  0, 0);
        // Enable abort with winner 9
        tbl[15] = mk(1, 1, 16'h0200, 16'h0200, 4'd9,  1, 0);
        tbl[16] = mk(1, 0, 16'h0200, 16'h0000, 4'd9,  0, 0);
        tbl[17] = mk(1, 0, 16'hFFFF, 16'h0000, 4'd9,  0, 0);
        tbl[18] = mk(1, 0, 16'hFFFF, 16'h0000, 4'd9,  0, 0);
        tbl[19] = mk(1, 1, 16'hFFFF, 16'h0400, 4'd10, 1, 0);
        tbl[20] = mk(1, 1, 16'h0000, 16'h0000, 4'd10, 0, 0);
        // Reset in the middle of a grant to 7
        tbl[21] = mk(1, 1, 16'h0080, 16'h0080, 4'd7,  1, 0);
        tbl[22] = mk(1, 1, 16'h0080, 16'h0080, 4'd7,  1, 0);
        tbl[23] = mk(0, 1, 16'hFFFF, 16'h0000, 4'd0,  0, 0);
        tbl[24] = mk(1, 1, 16'hFFFF, 16'h0001, 4'd0,  1, 0);
        tbl[25] = mk(1, 1, 16'h0000, 16'h0000, 4'd0,  0, 0);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Timeout: pointer is 1, requester 2 holds forever.
        for (int c = 1; c <= 16; c++) begin
            step(mk(1, 1, 16'h0004, 16'h0004, 4'd2, 1, 0), $sformatf("hold%0d", c));
        end
        step(mk(1, 1, 16'h0004, 16'h0000, 4'd2, 0, 1), "to_release");
        // Pointer is 3; scan wraps back to 2 after a single idle cycle.
        step(mk(1, 1, 16'h0004, 16'h0004, 4'd2, 1, 0), "regrant");
        for (int c = 2; c <= 16; c++) begin
            step(mk(1, 1, 16'h0004, 16'h0004, 4'd2, 1, 0), $sformatf("hold2_%0d", c));
        end
        // Request dropped exactly when the limit is reached: no timeout.
        step(mk(1, 1, 16'h0000, 16'h0000, 4'd2, 0, 0), "drop_at_limit");
        step(mk(1, 1, 16'h0000, 16'h0000, 4'd2, 0, 0), "idle_after");

        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
